// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared widths and state/owner encodings for the memory port
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int unsigned c_ADDR  = 16;
    localparam int unsigned c_W_OPR = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_select.sv
`default_nettype none
// ============================================================================
// Module      : arb_select
// Description : Two-requester combinational grant selector; the second
//               requester wins unless the first one is being forced.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_select (
    input  logic i_if_req,
    input  logic i_ls_req,
    input  logic i_force_if,
    output logic o_if_gnt,
    output logic o_ls_gnt
);

    assign o_ls_gnt = i_ls_req & ~(i_force_if & i_if_req);
    assign o_if_gnt = i_if_req & ~o_ls_gnt;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and the
//               load/store unit, one transaction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR       = c_ADDR,
    parameter int unsigned W_OPR      = c_W_OPR,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             if_req_i,
    input  logic [ADDR-1:0]  if_addr_i,
    output logic             if_gnt_o,
    output logic             if_rvalid_o,
    output logic [W_OPR-1:0] if_rdata_o,
    input  logic             ls_req_i,
    input  logic [ADDR-1:0]  ls_addr_i,
    input  logic             ls_write_i,
    input  logic [W_OPR-1:0] ls_wdata_i,
    output logic             ls_gnt_o,
    output logic             ls_rvalid_o,
    output logic [W_OPR-1:0] ls_rdata_o,
    output logic             mem_req_o,
    output logic [ADDR-1:0]  mem_addr_o,
    output logic             mem_write_o,
    output logic [W_OPR-1:0] mem_wdata_o,
    input  logic             mem_ready_i,
    input  logic             mem_rvalid_i,
    input  logic [W_OPR-1:0] mem_rdata_i
);

    localparam int unsigned        c_CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

    state_t             r_state;
    state_t             w_state_nxt;
    owner_t             r_owner;
    logic [c_CNT_W-1:0] r_starve_cnt;
    logic [ADDR-1:0]    r_addr;
    logic               r_write;
    logic [W_OPR-1:0]   r_wdata;

    logic w_if_req_arb;
    logic w_ls_req_arb;
    logic w_force_if;
    logic w_if_gnt;
    logic w_ls_gnt;

    // Requests only compete in IDLE; reset masks the combinational grants too.
    assign w_if_req_arb = if_req_i & (r_state == ST_IDLE) & ~rst_i;
    assign w_ls_req_arb = ls_req_i & (r_state == ST_IDLE) & ~rst_i;
    assign w_force_if   = (r_starve_cnt == c_STARVE_MAX);

    arb_select u_arb_select (
        .i_if_req   (w_if_req_arb),
        .i_ls_req   (w_ls_req_arb),
        .i_force_if (w_force_if),
        .o_if_gnt   (w_if_gnt),
        .o_ls_gnt   (w_ls_gnt)
    );

    assign if_gnt_o    = w_if_gnt;
    assign ls_gnt_o    = w_ls_gnt;
    assign mem_addr_o  = r_addr;
    assign mem_write_o = r_write;
    assign mem_wdata_o = r_wdata;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_req_o   = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        ls_rvalid_o = 1'b0;
        ls_rdata_o  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_if_gnt || w_ls_gnt) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    if (r_write) begin
                        // Stores complete on acceptance; no read data phase.
                        ls_rvalid_o = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    w_state_nxt = ST_IDLE;
                    if (r_owner == OWN_IF) begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_rdata_i;
                    end else begin
                        ls_rvalid_o = 1'b1;
                        ls_rdata_o  = mem_rdata_i;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner      <= OWN_IF;
            r_starve_cnt <= '0;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
        end else if (w_if_gnt) begin
            r_owner      <= OWN_IF;
            r_starve_cnt <= '0;
            r_addr       <= if_addr_i;
            r_write      <= 1'b0;
            r_wdata      <= '0;
        end else if (w_ls_gnt) begin
            r_owner <= OWN_LS;
            r_addr  <= ls_addr_i;
            r_write <= ls_write_i;
            r_wdata <= ls_wdata_i;
            // Only count LS wins that actually made a waiting fetch wait longer.
            if (if_req_i && (r_starve_cnt != c_STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench: directed cycle tables, corner sequences
//               and randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [15:0] if_addr_i = '0;
    logic        ls_req_i = 1'b0;
    logic [15:0] ls_addr_i = '0;
    logic        ls_write_i = 1'b0;
    logic [31:0] ls_wdata_i = '0;
    logic        mem_ready_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
    logic        mem_req_o, mem_write_o;
    logic [31:0] if_rdata_o, ls_rdata_o, mem_wdata_o;
    logic [15:0] mem_addr_o;
    logic [117:0] w_all;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.ADDR(16), .W_OPR(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_addr_i(ls_addr_i), .ls_write_i(ls_write_i),
        .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
        .ls_rdata_o(ls_rdata_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_write_o(mem_write_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    assign w_all = {if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
                    mem_req_o, mem_addr_o, mem_write_o, mem_wdata_o};

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ctl bits: {if_gnt, ls_gnt, mem_req, if_rvalid, ls_rvalid}
    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        ls_req;
        logic [15:0] ls_addr;
        logic        ls_write;
        logic [31:0] ls_wdata;
        logic        mem_ready;
        logic        mem_rvalid;
        logic [31:0] mem_rdata;
        logic [4:0]  exp_ctl;
        logic [15:0] exp_addr;
        logic        exp_write;
        logic [31:0] exp_wdata;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_ls_rdata;
    } vec_t;

    task automatic apply_vec(input vec_t v, input int idx);
        logic [127:0] act, exp;
        @(posedge clk_i); #1;
        rst_i        = 1'b0;
        if_req_i     = v.if_req;     if_addr_i  = v.if_addr;
        ls_req_i     = v.ls_req;     ls_addr_i  = v.ls_addr;
        ls_write_i   = v.ls_write;   ls_wdata_i = v.ls_wdata;
        mem_ready_i  = v.mem_ready;  mem_rvalid_i = v.mem_rvalid;
        mem_rdata_i  = v.mem_rdata;
        @(negedge clk_i);
        act = {if_gnt_o, ls_gnt_o, mem_req_o, if_rvalid_o, ls_rvalid_o, if_rdata_o, ls_rdata_o};
        exp = {v.exp_ctl, v.exp_if_rdata, v.exp_ls_rdata};
        // Command fields are only meaningful while a request is presented.
        if (v.exp_ctl[2]) begin
            act = {act[68:0], mem_addr_o, mem_write_o, mem_wdata_o};
            exp = {exp[68:0], v.exp_addr, v.exp_write, v.exp_wdata};
        end
        check($sformatf("vec%0d", idx), act, exp);
    endtask

    task automatic run_random(input int n_cyc);
        logic [31:0] ref_mem [16];
        logic [31:0] phys_mem [16];
        int          m_phase = 0;
        int          m_starve = 0;
        logic        m_owner_ls = 1'b0;
        logic [15:0] m_addr = '0;
        logic        m_write = 1'b0;
        logic [31:0] m_wdata = '0;
        logic        if_pend = 1'b0, ls_pend = 1'b0;
        int          if_wait = 0, ls_wait = 0;
        logic        resp_pend = 1'b0;
        int          resp_delay = 0;
        logic [3:0]  resp_addr = '0;
        logic        e_if_g, e_ls_g, e_if_rv, e_ls_rv;
        logic [31:0] e_if_d, e_ls_d;

        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = 32'h1000_0000 + i * 32'h0101_0101;
            phys_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
        end

        @(posedge clk_i); #1;
        rst_i = 1'b1;
        if_req_i = 1'b0; ls_req_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        for (int c = 0; c < n_cyc; c++) begin
            @(posedge clk_i); #1;
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend   = 1'b1;
                if_addr_i = 16'($urandom_range(0, 15));
            end
            if (!ls_pend && $urandom_range(0, 2) == 0) begin
                ls_pend    = 1'b1;
                ls_addr_i  = 16'($urandom_range(0, 15));
                ls_write_i = 1'($urandom_range(0, 1));
                ls_wdata_i = $urandom;
            end
            if_req_i    = if_pend;
            ls_req_i    = ls_pend;
            mem_ready_i = mem_req_o ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 3) == 0);
            if (resp_pend && resp_delay == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = phys_mem[resp_addr];
            end else begin
                mem_rvalid_i = !resp_pend && ($urandom_range(0, 7) == 0);
                mem_rdata_i  = $urandom;
                if (resp_pend) resp_delay--;
            end

            @(negedge clk_i);
            e_if_g = 1'b0; e_ls_g = 1'b0;
            if (m_phase == 0) begin
                if (ls_req_i && !(if_req_i && m_starve == STARVE_MAX)) e_ls_g = 1'b1;
                else if (if_req_i) e_if_g = 1'b1;
            end
            check("rnd_gnt", {if_gnt_o, ls_gnt_o}, {e_if_g, e_ls_g});
            check("rnd_mem_req", mem_req_o, m_phase == 1);
            if (m_phase == 1)
                check("rnd_mem_cmd", {mem_addr_o, mem_write_o, mem_wdata_o}, {m_addr, m_write, m_wdata});

            e_if_rv = 1'b0; e_ls_rv = 1'b0; e_if_d = '0; e_ls_d = '0;
            if (m_phase == 1 && mem_ready_i && m_write) e_ls_rv = 1'b1;
            if (m_phase == 2 && mem_rvalid_i) begin
                if (m_owner_ls) begin e_ls_rv = 1'b1; e_ls_d = ref_mem[m_addr[3:0]]; end
                else            begin e_if_rv = 1'b1; e_if_d = ref_mem[m_addr[3:0]]; end
            end
            check("rnd_resp", {if_rvalid_o, if_rdata_o, ls_rvalid_o, ls_rdata_o},
                              {e_if_rv, e_if_d, e_ls_rv, e_ls_d});

            case (m_phase)
                0: if (e_if_g || e_ls_g) begin
                    m_owner_ls = e_ls_g;
                    m_addr     = e_ls_g ? ls_addr_i : if_addr_i;
                    m_write    = e_ls_g & ls_write_i;
                    m_wdata    = e_ls_g ? ls_wdata_i : 32'h0;
                    if (e_if_g) m_starve = 0;
                    else if (if_req_i && m_starve < STARVE_MAX) m_starve++;
                    m_phase = 1;
                end
                1: if (mem_ready_i) begin
                    if (m_write) begin
                        ref_mem[m_addr[3:0]] = m_wdata;
                        m_phase = 0;
                    end else begin
                        m_phase = 2;
                    end
                end
                default: if (mem_rvalid_i) m_phase = 0;
            endcase

            if (resp_pend && mem_rvalid_i) resp_pend = 1'b0;
            if (mem_req_o && mem_ready_i) begin
                if (mem_write_o) begin
                    phys_mem[mem_addr_o[3:0]] = mem_wdata_o;
                end else begin
                    resp_pend  = 1'b1;
                    resp_addr  = mem_addr_o[3:0];
                    resp_delay = $urandom_range(0, 2);
                end
            end

            if (if_gnt_o) begin if_pend = 1'b0; if_wait = 0; end
            else if (if_pend && ++if_wait > 100) begin
                check("rnd_if_timeout", 1'b0, 1'b1); if_wait = 0;
            end
            if (ls_gnt_o) begin ls_pend = 1'b0; ls_wait = 0; end
            else if (ls_pend && ++ls_wait > 100) begin
                check("rnd_ls_timeout", 1'b0, 1'b1); ls_wait = 0;
            end
        end
    endtask

    initial begin
        vec_t vecs[$];
        logic exp_order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic got [10];
        int   ngr;

        // if_req, if_addr, ls_req, ls_addr, ls_write, ls_wdata, rdy, rvalid, rdata,
        // exp_ctl, exp_addr, exp_write, exp_wdata, exp_if_rdata, exp_ls_rdata
        vecs.push_back('{1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        5'b10000, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        5'b00100, 16'h0010, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h55555555, 5'b00000, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 5'b00010, 16'h0000, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 16'h0010, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        5'b00000, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 16'h0020, 1'b1, 16'h0100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        5'b01000, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 16'h0020, 1'b0, 16'h0100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        5'b00100, 16'h0100, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b1, 16'h0020, 1'b0, 16'h0100, 1'b0, 32'h0, 1'b0, 1'b1, 32'hA5A50001, 5'b00001, 16'h0000, 1'b0, 32'h0, 32'h0, 32'hA5A50001});
        vecs.push_back('{1'b1, 16'h0020, 1'b0, 16'h0100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,        5'b10000, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0020, 1'b0, 16'h0100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        5'b00100, 16'h0020, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0020, 1'b0, 16'h0100, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0BADF00D, 5'b00010, 16'h0000, 1'b0, 32'h0, 32'h0BADF00D, 32'h0});
        vecs.push_back('{1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0, 5'b01000, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0999, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 5'b00100, 16'h0100, 1'b1, 32'h12345678, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0999, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h77777777, 5'b00100, 16'h0100, 1'b1, 32'h12345678, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0999, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 5'b00100, 16'h0100, 1'b1, 32'h12345678, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0999, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 5'b00101, 16'h0100, 1'b1, 32'h12345678, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,        5'b00000, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 32'h0, 1'b0, 1'b1, 32'h13572468, 5'b00000, 16'h0000, 1'b0, 32'h0, 32'h0, 32'h0});

        // Reset with every request and memory strobe active: outputs stay quiet.
        if_req_i = 1'b1; if_addr_i = 16'h0010; ls_req_i = 1'b1; ls_addr_i = 16'h0100;
        mem_ready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        repeat (2) @(negedge clk_i);
        check("reset_outputs", w_all, '0);
        ls_req_i = 1'b0; mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

        // Both requesters held high: the fetch side is forced every fifth grant.
        @(posedge clk_i); #1;
        if_req_i = 1'b1; if_addr_i = 16'h0040;
        ls_req_i = 1'b1; ls_addr_i = 16'h0200; ls_write_i = 1'b0;
        mem_ready_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
        ngr = 0;
        for (int cyc = 0; cyc < 60 && ngr < 10; cyc++) begin
            @(negedge clk_i);
            check("starve_onehot", if_gnt_o & ls_gnt_o, 1'b0);
            if (if_gnt_o || ls_gnt_o) begin
                got[ngr] = ls_gnt_o;
                ngr++;
            end
        end
        for (int i = 0; i < 10; i++)
            check($sformatf("starve_order%0d", i), (i < ngr) ? {1'b0, got[i]} : 2'b10, {1'b0, exp_order[i]});
        @(posedge clk_i); #1;
        if_req_i = 1'b0; ls_req_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b0;

        // Reset while waiting for read data abandons the transaction.
        @(posedge clk_i); #1;
        if_req_i = 1'b1; if_addr_i = 16'h0030; mem_ready_i = 1'b1;
        @(negedge clk_i);
        check("rw_gnt", {if_gnt_o, ls_gnt_o}, 2'b10);
        @(posedge clk_i); #1;
        if_req_i = 1'b0;
        @(negedge clk_i);
        check("rw_req", {mem_req_o, mem_addr_o, mem_write_o}, {1'b1, 16'h0030, 1'b0});
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        check("rw_wait", {mem_req_o, if_rvalid_o, ls_rvalid_o}, 3'b000);
        #2 rst_i = 1'b1;
        #1 check("rw_in_reset", w_all, '0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFEF00D;
        @(negedge clk_i);
        check("rw_stray_rvalid", w_all, '0);
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0; if_req_i = 1'b1; if_addr_i = 16'h0034;
        @(negedge clk_i);
        check("rw_idle_gnt", {if_gnt_o, ls_gnt_o}, 2'b10);
        @(posedge clk_i); #1;
        if_req_i = 1'b0; mem_ready_i = 1'b1;
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11112222;
        @(negedge clk_i);
        check("rw_resume_resp", {if_rvalid_o, if_rdata_o, ls_rvalid_o}, {1'b1, 32'h11112222, 1'b0});
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;

        run_random(3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
